// File: rtl/toggle_decoder.sv
// rtl/toggle_decoder.sv - toggle-encoded serial line decoder with one-word output buffer and overrun flag
// Optional macro TOGGLE_DECODER_SYNC_EN adds a 2-flop input synchronizer on din.
module toggle_decoder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             asyncReset_n,
  input  logic             din,
  input  logic             sample_en,
  input  logic             frame_start,
  output logic [WIDTH-1:0] data,
  input  logic             ready,
  output logic             valid,
  output logic             overrun,
  input  logic             clr_ovr
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic             prev_q, prev_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             din_s;
  logic             word_done;
  logic             word_drop;
  logic [WIDTH-1:0] shreg_nx;

`ifdef TOGGLE_DECODER_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk or negedge asyncReset_n) begin
    if (!asyncReset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
    end
  end

  assign din_s = sync2_q;
`else
  assign din_s = din;
`endif

  // New bit enters at the MSB so the first-received bit ends at the LSB.
  assign shreg_nx = {din_s ^ prev_q, shreg_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    word_done = 1'b0;

    if (frame_start) begin
      state_d = SHIFT;
      prev_d  = din_s;
      shreg_d = '0;
      cnt_d   = '0;
    end else if (sample_en) begin
      prev_d = din_s;
      if (state_q == SHIFT) begin
        shreg_d = shreg_nx;
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d     = '0;
          word_done = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    word_drop = word_done && valid_q && !ready;

    if (word_done && !word_drop) begin
      data_d  = shreg_nx;
      valid_d = 1'b1;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end

    // A drop in the same cycle as clr_ovr keeps the flag set.
    if (word_drop) begin
      ovr_d = 1'b1;
    end else if (clr_ovr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge asyncReset_n) begin
    if (!asyncReset_n) begin
      state_q <= IDLE;
      prev_q  <= 1'b0;
      shreg_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data    = data_q;
  assign valid   = valid_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_toggle_decoder.sv
// tb/tb_toggle_decoder.sv - self-checking bench for toggle_decoder
module tb_toggle_decoder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         asyncReset_n;
  logic         din, sample_en, frame_start, ready, clr_ovr;
  logic [W-1:0] data;
  logic         valid, overrun;

  always #5 clk = ~clk;

  toggle_decoder #(.WIDTH(W)) dut (
    .clk          (clk),
    .asyncReset_n (asyncReset_n),
    .din          (din),
    .sample_en    (sample_en),
    .frame_start  (frame_start),
    .data         (data),
    .ready        (ready),
    .valid        (valid),
    .overrun      (overrun),
    .clr_ovr      (clr_ovr)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: decoded bits are collected in a queue and summed into a word.
  bit           m_active;
  bit           m_prev;
  bit           m_bits[$];
  logic [W-1:0] m_data;
  bit           m_valid, m_ovr;
  bit           m_h0, m_h1;
  logic [W-1:0] seen[$];

  typedef struct {
    bit           din, se, fs, rdy, clr;
    logic [W-1:0] d;
    bit           v, o;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_bits.delete(); m_prev = 0;
    m_data = '0; m_valid = 0; m_ovr = 0; m_h0 = 0; m_h1 = 0;
  endtask

  task automatic model_step();
    bit ds, done, drop;
    int unsigned acc;
`ifdef TOGGLE_DECODER_SYNC_EN
    ds = m_h1; m_h1 = m_h0; m_h0 = din;
`else
    ds = din;
`endif
    done = 0; acc = 0;
    if (frame_start) begin
      m_active = 1; m_bits.delete(); m_prev = ds;
    end else if (sample_en) begin
      if (m_active) begin
        m_bits.push_back(ds ^ m_prev);
        if (m_bits.size() == W) begin
          for (int i = 0; i < W; i++) if (m_bits[i]) acc += (1 << i);
          m_bits.delete();
          done = 1;
        end
      end
      m_prev = ds;
    end
    drop = done && m_valid && !ready;
    if (done && !drop) begin
      m_data = acc[W-1:0]; m_valid = 1;
    end else if (m_valid && ready) begin
      m_valid = 0;
    end
    if (drop) m_ovr = 1;
    else if (clr_ovr) m_ovr = 0;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("model data", data, m_data);
    chk("model valid", valid, m_valid);
    chk("model overrun", overrun, m_ovr);
    if (valid) seen.push_back(data);
  endtask

  // Hold din for three cycles before strobing so both din_s paths see the level.
  task automatic send_bit(input bit lvl, input bit fs);
    din = lvl; sample_en = 0; frame_start = 0;
    cycle(); cycle();
    sample_en = 1; frame_start = fs;
    cycle();
    sample_en = 0; frame_start = 0;
  endtask

  task automatic start_frame();
    frame_start = 1; cycle(); frame_start = 0;
  endtask

  function automatic vec_t mk(bit d_in, bit se, bit fs, bit rdy, bit clr, logic [W-1:0] d, bit v, bit o);
    vec_t t;
    t.din = d_in; t.se = se; t.fs = fs; t.rdy = rdy; t.clr = clr; t.d = d; t.v = v; t.o = o;
    return t;
  endfunction

  initial begin
    bit lvls[8];
    bit lvl;
    lvls = '{1, 1, 0, 0, 0, 1, 1, 0};

    tbl[0] = mk(0, 0, 1, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 8; i++)
      tbl[1+i] = mk(lvls[i], 1, 0, 0, 0, (i == 7) ? 8'hA5 : 8'h00, (i == 7), 0);
    tbl[9] = mk(0, 0, 0, 0, 0, 8'hA5, 1, 0);
    for (int i = 0; i < 8; i++)
      tbl[10+i] = mk(~i[0], 1, 0, 0, 0, 8'hA5, 1, (i == 7));
    tbl[18] = mk(0, 0, 0, 0, 1, 8'hA5, 1, 0);
    tbl[19] = mk(0, 0, 0, 1, 0, 8'hA5, 0, 0);

    asyncReset_n = 0; din = 0; sample_en = 0; frame_start = 0; ready = 0; clr_ovr = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    asyncReset_n = 1;
    chk("reset data", data, 0);
    chk("reset valid", valid, 0);
    chk("reset overrun", overrun, 0);

`ifndef TOGGLE_DECODER_SYNC_EN
    for (int i = 0; i < 20; i++) begin
      din = tbl[i].din; sample_en = tbl[i].se; frame_start = tbl[i].fs;
      ready = tbl[i].rdy; clr_ovr = tbl[i].clr;
      cycle();
      chk($sformatf("tbl[%0d] data", i), data, tbl[i].d);
      chk($sformatf("tbl[%0d] valid", i), valid, tbl[i].v);
      chk($sformatf("tbl[%0d] overrun", i), overrun, tbl[i].o);
    end
    sample_en = 0; clr_ovr = 0;
`endif

    // Delayed-strobe frame: decodes identically with or without the synchronizer.
    ready = 1; din = 0; cycle(); cycle(); ready = 0;
    start_frame();
    for (int i = 0; i < 8; i++) send_bit(lvls[i], 0);
    chk("delayed data", data, 8'hA5);
    chk("delayed valid", valid, 1);

    // Back-to-back frames with ready tied high.
    ready = 1; clr_ovr = 1; cycle(); clr_ovr = 0; cycle(); cycle();
    seen.delete();
    lvl = din;
    start_frame();
    for (int i = 0; i < 8; i++) begin lvl = ~lvl; send_bit(lvl, 0); end
    for (int i = 0; i < 8; i++) send_bit(lvl, 0);
    cycle(); cycle();
    chk("b2b pulses", seen.size(), 2);
    if (seen.size() == 2) begin
      chk("b2b word0", seen[0], 8'hFF);
      chk("b2b word1", seen[1], 8'h00);
    end
    chk("b2b overrun", overrun, 0);

    // frame_start coinciding with a strobe after 3 bits.
    din = 0; cycle(); cycle();
    seen.delete();
    start_frame();
    for (int i = 0; i < 3; i++) send_bit(1, 0);
    send_bit(0, 1);
    for (int i = 0; i < 8; i++) send_bit(lvls[i], 0);
    cycle();
    chk("realign pulses", seen.size(), 1);
    if (seen.size() == 1) chk("realign word", seen[0], 8'hA5);

    // Random stimulus against the model.
    for (int i = 0; i < 2000; i++) begin
      din = 1'($urandom);
      sample_en = ($urandom_range(0, 1) == 1);
      frame_start = ($urandom_range(0, 39) == 0);
      ready = ($urandom_range(0, 2) == 0);
      clr_ovr = ($urandom_range(0, 15) == 0);
      cycle();
    end
    sample_en = 0; frame_start = 0; clr_ovr = 0;

    // Asynchronous reset mid-frame with a held word and overrun pending.
    ready = 0; din = 0; cycle(); cycle();
    start_frame();
    lvl = 0;
    for (int i = 0; i < 19; i++) begin lvl = ~lvl; send_bit(lvl, 0); end
    chk("pre-reset valid", valid, 1);
    chk("pre-reset overrun", overrun, 1);
    #2;
    asyncReset_n = 0;
    #1;
    chk("async data", data, 0);
    chk("async valid", valid, 0);
    chk("async overrun", overrun, 0);
    model_reset();
    @(posedge clk);
    #1;
    asyncReset_n = 1;
    ready = 1;
    seen.delete();
    for (int i = 0; i < 10; i++) send_bit(1'($urandom), 0);
    chk("post-reset no word", seen.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/toggle_decoder.md
TOGGLE_DECODER -- requirements
Module: toggle_decoder

Interface
REQ-001 Parameter: WIDTH, 8, decoded word width in bits (range 2..32).
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: asyncReset_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: din  input  1  toggle-encoded serial line: a level change means bit 1, no change means bit 0.
REQ-005 Port: sample_en  input  1  one-cycle bit-time strobe; din is sampled only on cycles where it is high.
REQ-006 Port: frame_start  input  1  one-cycle pulse that aligns the bit counter and starts decoding.
REQ-007 Port: data  output  WIDTH  last completed word, first-received bit at LSB.
REQ-008 Port: valid  output  1  data holds an unconsumed word.
REQ-009 Port: ready  input  1  consumer accepts data on any cycle where valid && ready.
REQ-010 Port: overrun  output  1  sticky flag: a completed word was dropped.
REQ-011 Port: clr_ovr  input  1  synchronous clear of overrun.

Function
REQ-012 Two states, IDLE and SHIFT; reset enters IDLE.
REQ-013 Reference-level register prev is updated from the line sample (din_s) on every sample_en, in both states.
REQ-014 In IDLE, sample_en performs no decode and leaves the shift register and bit counter unchanged.
REQ-015 frame_start in any state: clear the bit counter and shift register, load prev <= din_s, enter SHIFT next cycle.
REQ-016 frame_start takes priority over a coincident sample_en, whose bit is discarded.
REQ-017 Decoded bit per sample_en in SHIFT is b = din_s ^ prev; the shift register shifts right with b entering at MSB, so the first bit ends at LSB.
REQ-018 The bit counter runs 0..WIDTH-1 and wraps to 0 after the WIDTH-th bit. SHIFT continues with back-to-back frames and needs no new frame_start.
REQ-019 Word completion is the sample_en carrying the WIDTH-th bit. On the next cycle, data holds the full word and valid=1, provided valid was 0 or valid && ready held in the completion cycle.
REQ-020 If valid=1 and ready=0 in the completion cycle: data and valid are unchanged, the new word is dropped, and overrun is set on the next cycle.
REQ-021 valid clears the cycle after valid && ready, unless a new word loads in that same cycle (REQ-019), in which case valid stays 1.
REQ-022 overrun stays set until clr_ovr=1. If a set event and clr_ovr coincide, the set wins.
REQ-023 data is stable while valid=1 and not accepted.

Reset
REQ-024 Assertion of asyncReset_n=0 immediately forces: state=IDLE, data=0, valid=0, overrun=0, bit counter=0, shift register=0, prev=0, synchronizer flops=0.
REQ-025 Reset mid-frame discards the partial word. After release, no word is produced until frame_start.
REQ-026 Reset release is synchronous to clk externally; the block adds no release synchronizer.

Configuration
REQ-027 Macro TOGGLE_DECODER_SYNC_EN defined: din passes through a 2-flop synchronizer, so din_s is din delayed 2 clk cycles.
REQ-028 Macro TOGGLE_DECODER_SYNC_EN undefined: din_s = din (combinational, no added latency). din must then be synchronous to clk.

Verification
REQ-029 Setup: WIDTH=8, macro undefined, din=0, frame_start pulse. Drive 8 sample_en strobes with din levels 1,1,0,0,0,1,1,0. Required: data=0xA5 and valid=1 on the cycle after the 8th strobe.
REQ-030 Setup: valid=1 held with ready=0. Complete a second word. Required: data remains 0xA5 and overrun=1. Then pulse clr_ovr; required: overrun=0.
REQ-031 Setup: ready tied 1. Decode two back-to-back frames with no second frame_start: first frame 0xFF (din toggles each strobe), second frame 0x00 (din constant). Required: two single-cycle valid pulses with data 0xFF then 0x00, and no overrun.
REQ-032 Pulse frame_start together with sample_en after 3 bits. Required: the partial word is discarded, the coincident bit is ignored, and the next 8 strobes form a word.
REQ-033 Drop asyncReset_n to 0 mid-frame between clock edges. Required: all outputs are 0 immediately. After release, strobes without frame_start produce no valid.
REQ-034 Macro defined, REQ-029 stimulus with sample_en delayed 2 cycles relative to the din changes. Required: data=0xA5.
